// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM states, default sizes and counter width helper for the systolic feed path
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  localparam int DEF_N = 3;
  localparam int DEF_DATA_WIDTH = 8;
  function automatic int cnt_w(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction
endpackage

// File: rtl/skew_buffer.sv
// skew_buffer: N zero-padded shift lanes, lane i delayed by i+1 cycles with a valid bit per stage
//   clk, reset_n          clock, async active-low reset
//   in_data, in_valid     one N-lane block captured when in_valid, zeros shifted otherwise
//   out_data, out_valid   lane i output of its last stage
module skew_buffer #(
  parameter int N = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [N-1:0]            out_valid
);
  for (genvar i = 0; i < N; i++) begin : lane
    logic [DATA_WIDTH-1:0] sr [i+1];
    logic                  vr [i+1];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s <= i; s++) begin
          sr[s] <= '0;
          vr[s] <= 1'b0;
        end
      end else begin
        sr[0] <= in_valid ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        vr[0] <= in_valid;
        for (int s = 1; s <= i; s++) begin
          sr[s] <= sr[s-1];
          vr[s] <= vr[s-1];
        end
      end
    end
    assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = sr[i];
    assign out_valid[i] = vr[i];
  end
endmodule

// File: rtl/matrix_feed_ctrl.sv
// matrix_feed_ctrl: sequences ROM block reads and skewed, zero-padded edge feeding of an NxN systolic array
//   clk, reset_n            clock, async active-low reset
//   start                   launch request, honoured only in IDLE
//   busy, done, pe_clear    run status, completion pulse, accumulator clear pulse
//   rom_rd_en, rom_addr     shared ROM read enable and block address
//   rom_a_data, rom_b_data  combinational ROM blocks (column k of A, row k of B)
//   a_feed, b_feed          west / north array edge inputs
//   feed_valid              {B lane valids, A lane valids}
module matrix_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N = DEF_N,
  localparam int ADDR_W = cnt_w(N*N)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    pe_clear,
  output logic                    rom_rd_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [N*DATA_WIDTH-1:0] rom_a_data,
  input  logic [N*DATA_WIDTH-1:0] rom_b_data,
  output logic [N*DATA_WIDTH-1:0] a_feed,
  output logic [N*DATA_WIDTH-1:0] b_feed,
  output logic [2*N-1:0]          feed_valid
);
  localparam int K_W = cnt_w(N);
  localparam int D_W = cnt_w(2*N-1);
  state_t         state;
  logic [K_W-1:0] k;
  logic [D_W-1:0] d;
  logic [N-1:0]   a_v, b_v;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      d         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_clear  <= 1'b0;
      rom_rd_en <= 1'b0;
      rom_addr  <= '0;
    end else begin
      done     <= 1'b0;
      pe_clear <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= FEED;
          k         <= '0;
          busy      <= 1'b1;
          pe_clear  <= 1'b1;
          rom_rd_en <= 1'b1;
          rom_addr  <= '0;
        end
        FEED: if (k == K_W'(N-1)) begin
          state     <= DRAIN;
          d         <= '0;
          rom_rd_en <= 1'b0;
          rom_addr  <= '0;
        end else begin
          k        <= k + K_W'(1);
          rom_addr <= rom_addr + ADDR_W'(N);
        end
        DRAIN: if (d == D_W'(2*N-2)) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          d <= d + D_W'(1);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
  // rom_rd_en is high exactly in FEED, so it doubles as the capture strobe for both skew lanes
  skew_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_skew_a (
    .clk(clk), .reset_n(reset_n), .in_data(rom_a_data), .in_valid(rom_rd_en),
    .out_data(a_feed), .out_valid(a_v)
  );
  skew_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH)) u_skew_b (
    .clk(clk), .reset_n(reset_n), .in_data(rom_b_data), .in_valid(rom_rd_en),
    .out_data(b_feed), .out_valid(b_v)
  );
  assign feed_valid = {b_v, a_v};
endmodule

// File: doc/matrix_feed_ctrl.md
# matrix_feed_ctrl

Sequencer that drives the matrix ROMs and feeds the N×N systolic array. One `start` pulse launches a multiply. The block reads N blocks from ROM A and N blocks from ROM B, skews each lane by its index and drives the array edges with zero padding. It then counts out the array drain and pulses `done`. It sits between the top-level control and the two ROMs and the array.

## Interface
- `DATA_WIDTH`, 8, element width in bits
- `N`, 3, array dimension; ROM depth is N*N and block size is N
- `ADDR_W`, `$clog2(N*N)`, derived ROM address width (localparam)
- `clk`  in  1  rising-edge clock, single clock domain
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  launch request; sampled only in IDLE
- `busy`  out  1  high from the first FEED cycle through DONE inclusive
- `done`  out  1  one-cycle pulse; results in the array are valid
- `pe_clear`  out  1  one-cycle pulse in FEED t=0; clears the PE accumulators
- `rom_rd_en`  out  1  read enable to both ROMs; high only in FEED
- `rom_addr`  out  ADDR_W  block address shared by both ROMs
- `rom_a_data`  in  N*DATA_WIDTH  ROM A block (column-major A, so the block is column k); lane i is at bits [i*DW +: DW]
- `rom_b_data`  in  N*DATA_WIDTH  ROM B block (row-major B, so the block is row k)
- `a_feed`  out  N*DATA_WIDTH  west-edge array inputs; lane i feeds row i
- `b_feed`  out  N*DATA_WIDTH  north-edge array inputs; lane j feeds column j
- `feed_valid`  out  2N  per-lane valid flags; bits [N-1:0] are A lanes, bits [2N-1:N] are B lanes

## Operation
- States: IDLE, FEED, DRAIN, DONE. Step counter `k` counts 0..N-1; drain counter `d` counts 0..2N-2.
- IDLE: `start`=1 → FEED, k=0. Otherwise stay in IDLE.
- FEED: `rom_rd_en`=1, `rom_addr`=k*N. Both ROM blocks are captured into skew lane inputs at the same edge. k=N-1 → DRAIN, d=0. Otherwise k+1.
- DRAIN: nothing is read. Skew lanes shift zeros. d=2N-2 → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Skew: lane i holds i+1 register stages. a_feed lane i = A[i][k] in cycle t=k+i+1, counted from the first FEED cycle t=0. b_feed lane j = B[k][j] in cycle t=k+j+1. Any lane with no valid data drives 0; padding is zero, never stale data.
- feed_valid bit for a lane is high exactly in the cycles that lane carries real data.
- ROMs are read combinationally: data is valid in the same cycle as `rom_addr`/`rom_rd_en`. No pass-through arithmetic; widths are preserved.
- `rom_addr`=0 whenever not in FEED.

## Timing
- Reset (asynchronous, while `reset_n`=0):
  - state=IDLE, k=0, d=0
  - `busy`, `done`, `pe_clear`, `rom_rd_en`=0
  - `rom_addr`=0, `a_feed`=`b_feed`=0, `feed_valid`=0
  - all skew registers cleared
- Release from reset is synchronous to the next rising edge of `clk`.
- Start-to-done latency: FEED occupies N cycles (t=0..N-1), DRAIN 2N-1 cycles, DONE at t=3N-1. `busy` is high for 3N cycles. For N=3, `done` is at t=8.
- Last valid feed data appears at t=2N-1.
- `start` in FEED, DRAIN or DONE is ignored. It is not queued.
- A new `start` is accepted no earlier than the cycle after DONE.
- Reset asserted mid-operation aborts immediately. Skew contents are discarded and no `done` is issued.
- `start` held high continuously produces back-to-back runs with one IDLE cycle between runs.

## Structure
- Package `systolic_pkg`:
  - state enum {IDLE, FEED, DRAIN, DONE}
  - default N and DATA_WIDTH
  - helper function for counter widths
- Sub-module `skew_buffer` (parameters N and DATA_WIDTH): N lanes, lane i a shift register of depth i+1, with a valid bit alongside each stage.
- Instantiate `skew_buffer` twice, once for A and once for B. The FSM and counters stay in `matrix_feed_ctrl`.
- Counter widths: k is `$clog2(N)`, d is `$clog2(2N-1)`, each with a minimum of 1 bit.

## Test plan
- Basic run, N=3. ROM A = 1,4,7,2,5,8,3,6,9 and ROM B = 1..9. Pulse `start`.
  - `rom_addr` = 0,3,6 at t=0..2.
  - a_feed lane0 = 1,2,3 at t1..3; lane1 = 4,5,6 at t2..4; lane2 = 7,8,9 at t3..5.
  - b_feed lane0 = 1,4,7 at t1..3.
  - `done` at t=8; `busy` high t0..t8.
- Zero padding: in the same run, a_feed lane2=0 and feed_valid[2]=0 at t1, t2 and t6..t8. All lanes are 0 in IDLE.
- `start` pulsed at t=4 (in DRAIN) → ignored. Exactly one `done`, at t=8. The next run requires a fresh `start`.
- `start` held high for 30 cycles → repeated runs. `done` pulses at t=8, 18 and 28 (10-cycle period).
- `reset_n` driven low at t=3 mid-run:
  - all outputs go 0 immediately, without waiting for a clock edge
  - no `done` follows
  - a subsequent `start` yields a clean run, with `done` 8 cycles after its t=0
- Parameter sweep N=4, DATA_WIDTH=16, ROM values 0xFFFF:
  - `rom_addr` = 0,4,8,12
  - `done` at t=11
  - lane3 valid at t=4..7 only
  - no width truncation
